keypad_entry: RTL and testbench

Operand-entry front end for the hex calculator. It scans a 4x4 hex matrix keypad, debounces it, and shifts each pressed digit into the selected 8-bit operand. It also debounces a select key and a go key, and presents `num1`, `num2`, `func` and a one-cycle `button` strobe. It produces the same signals the calculator core and display consume, replacing direct switch/button wiring, and runs in the divided system clock domain.

---
 rtl/keypad_entry.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_entry.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Hex keypad scanner/debouncer plus select/go push-button debounce feeding the calculator operands.
// Digit reaches operand one cycle after its debounce pass completes; button strobe is 2+DB_CYCLES+1 cycles after the raw edge.
module keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DB_CYCLES      = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  input  logic       btn_sel_raw,
  input  logic       btn_go_raw,
  input  logic [2:0] func_sw,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic [2:0] func,
  output logic       button,
  output logic       entry_sel
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int BW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DS_LAST = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_t;

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic          hit_acc;
  logic [3:0]    code_acc;
  logic          pass_vld, pass_hit;
  logic [3:0]    pass_code;
  logic          row_hit;
  logic [1:0]    row_num;
  logic [3:0]    col_code;
  logic          col_end;

  assign col_end  = (div_cnt == DW'(SCAN_DIV - 1));
  assign col_code = {row_num, col_idx};

  // Lowest-numbered low row wins within a column
  always_comb begin
    row_hit = ~&row_s2;
    row_num = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) row_num = 2'(r);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      key_col   <= 4'b1110;
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      hit_acc   <= 1'b0;
      code_acc  <= 4'd0;
      pass_vld  <= 1'b0;
      pass_hit  <= 1'b0;
      pass_code <= 4'd0;
    end else begin
      row_s1   <= key_row;
      row_s2   <= row_s1;
      pass_vld <= 1'b0;
      if (col_end) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        key_col <= ~(4'b0001 << (col_idx + 2'd1));
        if (col_idx == 2'd3) begin
          pass_vld  <= 1'b1;
          pass_hit  <= hit_acc | row_hit;
          pass_code <= hit_acc ? code_acc : col_code;
          hit_acc   <= 1'b0;
        end else if (!hit_acc && row_hit) begin
          hit_acc  <= 1'b1;
          code_acc <= col_code;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  kp_state_t     state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          press;
  logic [3:0]    press_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    press     = 1'b0;
    press_dat = 4'd0;
    if (pass_vld) begin
      case (state)
        IDLE: if (pass_hit) begin
          cand_n = pass_code;
          cnt_n  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            state_n   = HELD;
            press     = 1'b1;
            press_dat = pass_code;
          end else begin
            state_n = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (pass_hit && pass_code == cand) begin
            if (cnt == DS_LAST) begin
              state_n   = HELD;
              press     = 1'b1;
              press_dat = cand;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: if (!pass_hit) begin
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE_SCANS == 1) ? IDLE : REL_DB;
        end
        REL_DB: begin
          if (pass_hit) begin
            state_n = HELD;
          end else if (cnt == DS_LAST) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Index 0 = select, index 1 = go
  logic [1:0]    b_raw, b_s1, b_s2, b_db, b_dbq, b_rise;
  logic [BW-1:0] b_cnt [2];

  assign b_raw  = {btn_go_raw, btn_sel_raw};
  assign b_rise = b_db & ~b_dbq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_s1  <= 2'b00;
      b_s2  <= 2'b00;
      b_db  <= 2'b00;
      b_dbq <= 2'b00;
      for (int i = 0; i < 2; i++) b_cnt[i] <= '0;
    end else begin
      b_s1  <= b_raw;
      b_s2  <= b_s1;
      b_dbq <= b_db;
      for (int i = 0; i < 2; i++) begin
        if (b_s2[i] != b_db[i]) begin
          if (b_cnt[i] == BW'(DB_CYCLES - 1)) begin
            b_db[i]  <= b_s2[i];
            b_cnt[i] <= '0;
          end else begin
            b_cnt[i] <= b_cnt[i] + 1'b1;
          end
        end else begin
          b_cnt[i] <= '0;
        end
      end
    end
  end

  logic go_pend, go_fire;
  // A go edge coinciding with a digit waits one cycle so the strobe sees the new operand
  assign go_fire = go_pend | (b_rise[1] & ~press);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num1      <= 8'd0;
      num2      <= 8'd0;
      func      <= 3'd0;
      button    <= 1'b0;
      entry_sel <= 1'b0;
      go_pend   <= 1'b0;
    end else begin
      if (press) begin
        if (entry_sel) num2 <= {num2[3:0], press_dat};
        else           num1 <= {num1[3:0], press_dat};
      end
      if (b_rise[0]) entry_sel <= ~entry_sel;
      button  <= go_fire;
      go_pend <= b_rise[1] & press;
      if (go_fire) func <= func_sw;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: stimulus queues expected output events, a negedge monitor pops and compares.
module tb_keypad_entry;
  localparam int SD = 4;
  localparam int DS = 2;
  localparam int DB = 8;
  localparam int K_NUM1 = 0, K_NUM2 = 1, K_SEL = 2, K_BTN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       btn_sel_raw, btn_go_raw;
  logic [2:0] func_sw;
  logic [7:0] num1, num2;
  logic [2:0] func;
  logic       button, entry_sel;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .btn_sel_raw(btn_sel_raw), .btn_go_raw(btn_go_raw), .func_sw(func_sw),
    .num1(num1), .num2(num2), .func(func), .button(button), .entry_sel(entry_sel)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low
  int pressed = -1;
  always_comb begin
    key_row = 4'hF;
    if (pressed >= 0 && key_col[pressed % 4] == 1'b0) key_row[pressed / 4] = 1'b0;
  end

  int edge_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  typedef struct {int kind; int val;} ev_t;
  ev_t  exp_q[$];
  int   n_cmp = 0, n_fail = 0;
  bit   mon_en = 1'b0;
  logic [7:0] p1 = 8'd0, p2 = 8'd0;
  logic       psel = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input string nm, input int k, input int v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event value 0x%0h, none pending", nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL %s: got kind %0d val 0x%0h, want kind %0d val 0x%0h", nm, k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (num1 !== p1)      got_ev("num1", K_NUM1, int'(num1));
      if (num2 !== p2)      got_ev("num2", K_NUM2, int'(num2));
      if (entry_sel !== psel) got_ev("entry_sel", K_SEL, int'(entry_sel));
      if (button === 1'b1)  got_ev("button", K_BTN, int'(func));
      p1   = num1;
      p2   = num2;
      psel = entry_sel;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int n);
    int g = 0;
    while (edge_cnt < n && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 5000) chk("wait_edge_timeout", edge_cnt, n);
  endtask

  task automatic align16();
    int g = 0;
    while ((edge_cnt % 16) != 0 && g < 32) begin
      cyc(1);
      g++;
    end
  endtask

  task automatic press_key(input int k, input int hold);
    pressed = k;
    cyc(hold);
    pressed = -1;
    cyc(64);
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int base;
    logic [3:0] ec;
    rst = 1'b0;
    btn_sel_raw = 1'b0;
    btn_go_raw  = 1'b0;
    func_sw     = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_key_col", int'(key_col), 4'hE);
    chk("rst_num1", int'(num1), 0);
    chk("rst_num2", int'(num2), 0);
    chk("rst_func", int'(func), 0);
    chk("rst_button", int'(button), 0);
    chk("rst_entry_sel", int'(entry_sel), 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Column drive cycles every SD cycles
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      ec = 4'hF;
      ec[(n / 4) % 4] = 1'b0;
      chk("key_col_scan", int'(key_col), int'(ec));
    end
    @(posedge clk);
    #1;

    expect_ev(K_NUM1, 8'h0A);
    press_key(10, 48);
    expect_ev(K_NUM1, 8'hA5);
    press_key(5, 48);
    chk("num1_after_A5", int'(num1), 8'hA5);
    chk("num2_untouched", int'(num2), 0);

    // Single-pass bounce must not register
    press_key(7, 16);
    chk("bounce_rejected", int'(num1), 8'hA5);

    expect_ev(K_NUM1, 8'h53);
    press_key(3, 160);
    chk("hold_single_press", int'(num1), 8'h53);

    repeat (4) begin
      btn_sel_raw = 1'b1;
      cyc(3);
      btn_sel_raw = 1'b0;
      cyc(3);
    end
    cyc(20);
    chk("sel_bounce_rejected", int'(entry_sel), 0);

    expect_ev(K_SEL, 1);
    btn_sel_raw = 1'b1;
    cyc(20);
    btn_sel_raw = 1'b0;
    cyc(20);
    chk("sel_toggled", int'(entry_sel), 1);

    expect_ev(K_NUM2, 8'h01);
    press_key(1, 48);
    expect_ev(K_NUM2, 8'h12);
    press_key(2, 48);
    chk("num2_12", int'(num2), 8'h12);
    chk("num1_kept", int'(num1), 8'h53);

    func_sw = 3'b010;
    expect_ev(K_BTN, 2);
    btn_go_raw = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      chk("go_strobe_timing", int'(button), (j == 11) ? 1 : 0);
    end
    chk("func_latched", int'(func), 2);
    @(posedge clk);
    #1;
    cyc(37);
    btn_go_raw = 1'b0;
    cyc(20);

    // Digit press and go edge land in the same cycle
    func_sw = 3'b101;
    align16();
    base = edge_cnt;
    expect_ev(K_NUM2, 8'h24);
    expect_ev(K_BTN, 5);
    pressed = 4;
    wait_edge(base + 22);
    btn_go_raw = 1'b1;
    wait_edge(base + 33);
    @(negedge clk);
    chk("same_cycle_num2", int'(num2), 8'h24);
    chk("same_cycle_no_btn_yet", int'(button), 0);
    @(negedge clk);
    chk("same_cycle_btn_deferred", int'(button), 1);
    @(posedge clk);
    #1;
    cyc(20);
    btn_go_raw = 1'b0;
    pressed = -1;
    cyc(64);

    // Reset during PRESS_DB with a go pending
    align16();
    base = edge_cnt;
    pressed = 6;
    wait_edge(base + 20);
    btn_go_raw = 1'b1;
    wait_edge(base + 26);
    expect_ev(K_NUM1, 0);
    expect_ev(K_NUM2, 0);
    expect_ev(K_SEL, 0);
    rst = 1'b0;
    cyc(10);
    pressed = -1;
    btn_go_raw = 1'b0;
    cyc(2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(60);
    chk("midrst_num1", int'(num1), 0);
    chk("midrst_num2", int'(num2), 0);
    chk("midrst_func", int'(func), 0);
    chk("midrst_button", int'(button), 0);

    cyc(20);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
